// File: rtl/alu_op_issue.sv
// Issue stage for the 8-bit signed ALU: buffers requests in a small FIFO and
// presents one registered op per cycle, optionally forwarding the ALU result into A.
module alu_op_issue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 3,
  parameter int ALU_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_fwd,
  input  logic                     stall,
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] alu_c,
  output logic                     out_valid,
  output logic [SEL_W-1:0]         out_sel,
  output logic signed [DATA_W-1:0] out_a,
  output logic signed [DATA_W-1:0] out_b,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(ALU_LAT + 1);
  localparam int ENT_W = SEL_W + 2 * DATA_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1'b1);

  logic [ENT_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [LAT_W-1:0]  lat_cnt_r;

  logic [ENT_W-1:0]  head_s;
  logic [SEL_W-1:0]  head_sel_s;
  logic [DATA_W-1:0] head_a_s;
  logic [DATA_W-1:0] head_b_s;
  logic              head_fwd_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              issue_s;

  // Head decode and handshake/issue decisions; full FIFO never accepts, even alongside a pop.
  always_comb begin
    head_s     = mem_r[rd_ptr_r];
    head_sel_s = head_s[ENT_W-1 -: SEL_W];
    head_a_s   = head_s[2*DATA_W -: DATA_W];
    head_b_s   = head_s[DATA_W -: DATA_W];
    head_fwd_s = head_s[0];
    full_s     = (cnt_r == FULL_CNT);
    empty_s    = (cnt_r == {CNT_W{1'b0}});
    push_s     = in_valid && !full_s && !flush;
    issue_s    = !empty_s && !stall && !flush &&
                 (!head_fwd_s || (lat_cnt_r == {LAT_W{1'b0}}));
  end

  assign in_ready = !full_s;
  assign level    = cnt_r;

  // FIFO storage; contents need no reset because the pointers and count gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_sel, in_a, in_b, in_fwd};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and the result-latency counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      lat_cnt_r <= {LAT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      lat_cnt_r <= {LAT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, issue_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
      if (issue_s) begin
        lat_cnt_r <= LAT_LOAD;
      end else if (lat_cnt_r != {LAT_W{1'b0}}) begin
        lat_cnt_r <= lat_cnt_r - LAT_ONE;
      end else begin
        lat_cnt_r <= lat_cnt_r;
      end
    end
  end

  // Registered ALU-facing outputs; data holds whenever nothing issues.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sel   <= {SEL_W{1'b0}};
      out_a     <= {DATA_W{1'b0}};
      out_b     <= {DATA_W{1'b0}};
    end else if (issue_s) begin
      out_valid <= 1'b1;
      out_sel   <= head_sel_s;
      out_a     <= head_fwd_s ? alu_c : head_a_s;
      out_b     <= head_b_s;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Self-checking bench for alu_op_issue: queue-based reference model, directed
// scenarios with literal expectations, then constrained-random traffic.
module tb_alu_op_issue;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_sel;
  logic signed [7:0] in_a;
  logic signed [7:0] in_b;
  logic              in_fwd;
  logic              stall;
  logic              flush;
  logic signed [7:0] alu_c;
  logic              out_valid;
  logic [2:0]        out_sel;
  logic signed [7:0] out_a;
  logic signed [7:0] out_b;
  logic [2:0]        level;

  alu_op_issue #(.DEPTH(DEPTH), .DATA_W(8), .SEL_W(3), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_a(in_a), .in_b(in_b), .in_fwd(in_fwd),
    .stall(stall), .flush(flush), .alu_c(alu_c), .out_valid(out_valid),
    .out_sel(out_sel), .out_a(out_a), .out_b(out_b), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        sel;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic              fwd;
  } ent_t;

  ent_t              q[$];
  int                m_lat;
  logic              exp_valid;
  logic [2:0]        exp_sel;
  logic signed [7:0] exp_a;
  logic signed [7:0] exp_b;
  logic              acc;
  logic              chk_en = 1'b0;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference behaviour for one rising edge, from the inputs held before it.
  task automatic model_step();
    ent_t h;
    logic do_issue;
    acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_lat = 0;
      exp_valid = 1'b0; exp_sel = 3'd0; exp_a = 8'sd0; exp_b = 8'sd0;
    end else if (flush) begin
      q.delete();
      m_lat = 0;
      exp_valid = 1'b0;
    end else begin
      acc = in_valid && (q.size() != DEPTH);
      do_issue = (q.size() > 0) && !stall && (!q[0].fwd || m_lat == 0);
      if (do_issue) begin
        h = q.pop_front();
        exp_valid = 1'b1;
        exp_sel = h.sel;
        exp_a = h.fwd ? alu_c : h.a;
        exp_b = h.b;
        m_lat = ALU_LAT;
      end else begin
        exp_valid = 1'b0;
        if (m_lat > 0) m_lat--;
      end
      if (acc) begin
        h.sel = in_sel; h.a = in_a; h.b = in_b; h.fwd = in_fwd;
        q.push_back(h);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("out_sel", int'(out_sel), int'(exp_sel));
      chk("out_a", int'(out_a), int'(exp_a));
      chk("out_b", int'(out_b), int'(exp_b));
      chk("level", int'(level), q.size());
      chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
    end
  end

  task automatic set_op(input int sel, input int a, input int b, input logic fwd);
    in_valid = 1'b1;
    in_sel = 3'(sel); in_a = 8'(a); in_b = 8'(b); in_fwd = fwd;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 3'd0; in_a = 8'sd0; in_b = 8'sd0;
    in_fwd = 1'b0; stall = 1'b0; flush = 1'b0; alu_c = 8'sd0;
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_a", int'(out_a), 0);
    chk("rst level", int'(level), 0);
    chk("rst in_ready", int'(in_ready), 1);

    // Single push: pulse two cycles later.
    set_op(0, 5, -3, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("single level1", int'(level), 1);
    chk("single no bypass", int'(out_valid), 0);
    tick();
    chk("single out_valid", int'(out_valid), 1);
    chk("single out_a", int'(out_a), 5);
    chk("single out_b", int'(out_b), -3);
    chk("single level0", int'(level), 0);
    tick();
    chk("single pulse end", int'(out_valid), 0);

    // Six ops against a stalled FIFO, then release.
    stall = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
      if (cyc == 6) stall = 1'b0;
      if (cyc == 5) begin
        chk("stall level4", int'(level), 4);
        chk("stall in_ready0", int'(in_ready), 0);
      end
      if (cyc == 7) chk("full pop refuse", int'(level), 3);
      set_op(k + 1, 20 + k, k, 1'b0);
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("stall all sent", k, 6);
    repeat (8) tick();

    // Forward after a dependency: op2 takes alu_c from T+2.
    alu_c = 8'sd17;
    set_op(1, 10, 1, 1'b0);
    tick();
    set_op(2, 99, 2, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("fwd T op1", int'(out_a), 10);
    tick();
    chk("fwd T+1 idle", int'(out_valid), 0);
    tick();
    alu_c = 8'sd42;
    chk("fwd T+2 idle", int'(out_valid), 0);
    tick();
    alu_c = 8'sd17;
    chk("fwd T+3 valid", int'(out_valid), 1);
    chk("fwd T+3 out_a", int'(out_a), 42);
    repeat (4) tick();

    // Flush with three buffered entries and a concurrent push.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(i, 30 + i, i, 1'b0);
      tick();
    end
    chk("flush pre level", int'(level), 3);
    flush = 1'b1;
    set_op(7, 77, 7, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
    chk("flush level", int'(level), 0);
    chk("flush out_valid", int'(out_valid), 0);
    tick();
    chk("flush no issue", int'(out_valid), 0);
    tick();
    chk("flush no issue2", int'(out_valid), 0);

    // Reset mid-burst with two entries and lat_cnt=1.
    set_op(1, 1, 1, 1'b0);
    tick();
    set_op(2, 2, 2, 1'b0);
    tick();
    stall = 1'b1;
    set_op(3, 3, 3, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mid level2", int'(level), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stall = 1'b0; alu_c = 8'sd33;
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst out_a", int'(out_a), 0);
    chk("mid rst level", int'(level), 0);
    chk("mid rst in_ready", int'(in_ready), 1);
    set_op(4, 7, 4, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mid fwd wait", int'(out_valid), 0);
    tick();
    chk("mid fwd valid", int'(out_valid), 1);
    chk("mid fwd out_a", int'(out_a), 33);
    tick();

    // Random traffic; the source holds a request until it is accepted.
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_sel = 3'($urandom);
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_fwd = ($urandom_range(0, 9) < 4);
      end
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      alu_c = 8'($urandom);
      tick();
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Upstream issue stage for the 8-bit signed ALU. It accepts operation requests (select code, operand A, operand B, forward flag) over a valid/ready handshake and buffers them in a small FIFO. It presents one operation per cycle on registered `sel`/`A`/`B`-style outputs that drive the ALU directly. When a request's forward flag is set, operand A is replaced by the ALU's current result `C`, and the request is held until that result is known to be valid.

## Interface

Parameters:
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 2
- `DATA_W`, 8 — operand and result width (signed)
- `SEL_W`, 3 — select code width
- `ALU_LAT`, 2 — cycles from an op appearing on `out_*` to its result appearing on `alu_c`; ≥ 1

Ports (one synchronous clock; reset is synchronous and active-low):
- `clk` in 1 — sole clock, rising edge
- `rst_n` in 1 — synchronous, active-low reset
- `in_valid` in 1 — request present
- `in_ready` out 1 — FIFO can accept; equals `count != DEPTH`
- `in_sel` in SEL_W — select code
- `in_a` in DATA_W — operand A (signed)
- `in_b` in DATA_W — operand B (signed)
- `in_fwd` in 1 — replace A with `alu_c` at issue time
- `stall` in 1 — inhibit issue this cycle
- `flush` in 1 — discard all buffered requests
- `alu_c` in DATA_W — ALU result feedback
- `out_valid` out 1 — `out_*` holds a newly issued op this cycle
- `out_sel` out SEL_W — to ALU `sel`
- `out_a` out DATA_W — to ALU `A`
- `out_b` out DATA_W — to ALU `B`
- `level` out $clog2(DEPTH)+1 — current FIFO occupancy

## Operation

- FIFO entry = {sel, a, b, fwd}. Push when `in_valid && in_ready`; data is written at the rising edge.
- `lat_cnt` counter, range 0..ALU_LAT:
  - loads ALU_LAT on every issue edge
  - otherwise decrements when nonzero
- Issue condition at an edge: FIFO non-empty, `!stall`, `!flush`, and (head.fwd == 0 or `lat_cnt == 0`).
- On issue:
  - pop the head
  - register `out_sel` = head.sel, `out_b` = head.b
  - register `out_a` = head.fwd ? `alu_c` : head.a, with `alu_c` sampled in the issue cycle
  - set `out_valid` = 1
- No issue: `out_valid` = 0 the next cycle; `out_sel`/`out_a`/`out_b` hold their previous values.
- A stalled forward-flagged head blocks every entry behind it; issue is strictly in order.
- Full FIFO: `in_ready` = 0 even if a pop occurs in the same cycle (no full-bypass). Simultaneous push and pop when not full leaves `level` unchanged.
- Empty FIFO: a push is not issued in the same cycle (no empty-bypass).
- `flush` (highest priority after reset), at the edge:
  - count, read pointer, write pointer → 0
  - `out_valid` → 0
  - `lat_cnt` → 0
  - any push in the same cycle is dropped
  - `out_*` data holds
- Pointers wrap modulo DEPTH. `level` is an explicit counter, not a pointer difference.
- Forwarding with no prior issue since reset uses `alu_c` as presented; the block does not qualify it further.

## Timing

- Reset (`rst_n` = 0 at an edge): `out_valid` = 0, `out_sel` = 0, `out_a` = 0, `out_b` = 0, `level` = 0, `lat_cnt` = 0, `in_ready` = 1 after the edge. Reset mid-operation drops all buffered entries.
- Minimum latency: push at the edge ending cycle N → head valid in N+1 → issue edge ending N+1 → `out_valid` = 1 in cycle N+2.
- Throughput: one issue per cycle for non-forward ops.
- Back-to-back dependency: an op on `out_*` in cycle T loads `lat_cnt` = ALU_LAT, so `lat_cnt` = ALU_LAT−k in cycle T+k. A following fwd op issues at the end of cycle T+ALU_LAT, capturing `alu_c` from that cycle, and appears on `out_*` in T+ALU_LAT+1. The fwd-to-fwd issue interval is ALU_LAT+1 cycles.
- `in_ready` and `level` are combinational from registered count only; there is no path from `in_valid` to `in_ready`.

## Test plan

- Reset then single push (sel=0, a=5, b=−3, fwd=0) → `out_valid` pulses one cycle, 2 cycles after the push, with `out_a`=5, `out_b`=−3; `level` goes 1 then 0.
- Push 6 ops back-to-back with `stall`=1 → `in_ready` drops after the 4th push, `level`=4, the 5th and 6th are held by the source. Release `stall` → 4 consecutive `out_valid` cycles in push order, then the remaining 2.
- ALU_LAT=2; push op1 (fwd=0, a=10) followed by op2 (fwd=1, a=99); drive `alu_c`=42 in cycle T+2 → op2 appears in T+3 with `out_a`=42 (not 99); `out_valid` is low in T+1 and T+2.
- Full FIFO with a simultaneous pop and `in_valid`=1 → push refused that cycle, `level` 4→3, accepted the next cycle.
- `flush` asserted with 3 buffered entries and a concurrent push → next cycle `level`=0, `out_valid`=0, no further issues.
- Assert `rst_n`=0 for one edge mid-burst with 2 entries and `lat_cnt`=1 → all outputs 0, a fwd op pushed afterwards issues at the minimum 2-cycle latency.
